panel_scan_ctrl: RTL and testbench

PANEL_SCAN_CTRL -- requirements
Module: panel_scan_ctrl

---
 rtl/panel_pkg.sv | 23 ++
 rtl/panel_disp_timer.sv | 57 +++++
 rtl/panel_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_panel_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared defaults and types for the HUB-style LED panel scan controller.
package panel_pkg;

    localparam int DEF_COLS = 64;
    localparam int DEF_ROWS = 16;
    localparam int DEF_WIN  = 256;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        WAIT_DISP,
        BLANK,
        LATCH
    } scan_state_t;

    // Colour bits for the upper-half and lower-half pixels shifted together.
    typedef struct packed {
        logic [2:0] upper;
        logic [2:0] lower;
    } rgb_pair_t;

endpackage

// File: rtl/panel_disp_timer.sv
// Per-row display window counter and output-enable generator.
// Optional macro SCAN_DIM_EN limits the lit part of each window to 'bright' cycles.
module panel_disp_timer
    import panel_pkg::*;
#(
    parameter int WIN = DEF_WIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bright,
    output logic       busy,
    output logic       oe_n
);

    localparam int CNT_W = $clog2(WIN + 1);
    localparam int CMP_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lit_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = CNT_W'(WIN);
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

`ifdef SCAN_DIM_EN
    // Cycles already shown in this window; lit only while below the brightness.
    logic [CNT_W-1:0] elapsed_next;
    assign elapsed_next = CNT_W'(WIN) - cnt_next;
    assign lit_next     = (cnt_next != '0) && (CMP_W'(elapsed_next) < CMP_W'(bright));
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit_next      = (cnt_next != '0);
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            oe_n <= 1'b1;
        end else begin
            cnt  <= cnt_next;
            oe_n <= !lit_next;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/panel_scan_ctrl.sv
// Row-scanning controller for a 1/ROWS-scan RGB LED panel: fetches pixel pairs,
// shifts them out, latches each row and times its display. Macro: SCAN_DIM_EN.
module panel_scan_ctrl
    import panel_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int WIN  = DEF_WIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [7:0]              bright,
    output logic                    pix_req,
    output logic [$clog2(ROWS)-1:0] pix_row,
    output logic [$clog2(COLS)-1:0] pix_col,
    input  logic                    pix_valid,
    input  logic [2:0]              pix_rgb0,
    input  logic [2:0]              pix_rgb1,
    output logic [2:0]              rgb0,
    output logic [2:0]              rgb1,
    output logic                    sclk,
    output logic                    lat,
    output logic                    oe_n,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic                    frame_done
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    scan_state_t      state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] shift_row;
    logic [ROW_W-1:0] next_row;
    logic             stopping;
    rgb_pair_t        pix;
    logic             disp_busy;

    assign next_row = (shift_row == ROW_W'(ROWS - 1)) ? '0 : shift_row + ROW_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            shift_row  <= '0;
            stopping   <= 1'b0;
            pix        <= '0;
            pix_req    <= 1'b0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        col       <= '0;
                        shift_row <= row_addr;
                        pix_req   <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (pix_valid) begin
                        pix.upper <= pix_rgb0;
                        pix.lower <= pix_rgb1;
                        pix_req   <= 1'b0;
                        sclk      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sclk <= 1'b0;
                    if (col == COL_W'(COLS - 1)) begin
                        state <= WAIT_DISP;
                    end else begin
                        col     <= col + COL_W'(1);
                        pix_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                // The shifted row waits here until the previous row has been shown.
                WAIT_DISP: begin
                    if (!disp_busy) begin
                        if (stopping) begin
                            stopping <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    lat        <= 1'b1;
                    row_addr   <= shift_row;
                    frame_done <= (shift_row == ROW_W'(ROWS - 1));
                    state      <= LATCH;
                end
                LATCH: begin
                    lat        <= 1'b0;
                    frame_done <= 1'b0;
                    if (en) begin
                        col       <= '0;
                        shift_row <= next_row;
                        pix_req   <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        // Let the just-latched row finish its window before idling.
                        stopping <= 1'b1;
                        state    <= WAIT_DISP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix_row = shift_row;
    assign pix_col = col;
    assign rgb0    = pix.upper;
    assign rgb1    = pix.lower;

    panel_disp_timer #(
        .WIN (WIN)
    ) u_disp_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == LATCH),
        .bright (bright),
        .busy   (disp_busy),
        .oe_n   (oe_n)
    );

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Directed bench for panel_scan_ctrl at default COLS/ROWS/WIN; honours SCAN_DIM_EN.
module tb_panel_scan_ctrl;

`ifdef SCAN_DIM_EN
    localparam int EXP_LIT  = 10;
    localparam int DIM_ROWS = 1;
`else
    localparam int EXP_LIT  = 256;
    localparam int DIM_ROWS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] bright;
    logic       pix_req;
    logic [3:0] pix_row;
    logic [5:0] pix_col;
    logic       pix_valid;
    logic [2:0] pix_rgb0;
    logic [2:0] pix_rgb1;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic [3:0] row_addr;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cyc, acc_sclk, acc_oe, acc_lat, acc_fd;

    always #5 clk = ~clk;

    // Pixel source: colour bits derived from the requested address.
    assign pix_rgb0 = pix_col[2:0];
    assign pix_rgb1 = pix_row[2:0];

    panel_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bright     (bright),
        .pix_req    (pix_req),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_valid  (pix_valid),
        .pix_rgb0   (pix_rgb0),
        .pix_rgb1   (pix_rgb1),
        .rgb0       (rgb0),
        .rgb1       (rgb1),
        .sclk       (sclk),
        .lat        (lat),
        .oe_n       (oe_n),
        .row_addr   (row_addr),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        acc_cyc = 0; acc_sclk = 0; acc_oe = 0; acc_lat = 0; acc_fd = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            acc_cyc++;
            if (sclk === 1'b1)       acc_sclk++;
            if (oe_n === 1'b0)       acc_oe++;
            if (lat === 1'b1)        acc_lat++;
            if (frame_done === 1'b1) acc_fd++;
        end
    endtask

    task automatic run_until_lat(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (lat === 1'b1) seen = 1'b1;
        end
        check("lat_seen", 32'(seen), 1);
    endtask

    initial begin
        int fd_total;
        int stall_cnt;
        bit got_sclk;

        rst = 1'b1; en = 1'b1; bright = 8'd10; pix_valid = 1'b1;
        clear_acc();
        step(3);
        check("rst_oe_n", oe_n, 1);
        check("rst_lat", lat, 0);
        check("rst_sclk", sclk, 0);
        check("rst_rgb0", rgb0, 0);
        check("rst_rgb1", rgb1, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_pix_req", pix_req, 0);
        check("rst_pix_row", pix_row, 0);
        check("rst_pix_col", pix_col, 0);
        check("rst_frame_done", frame_done, 0);

        // Row 0 from IDLE: 64 x (FETCH+SHIFT), WAIT_DISP, BLANK, LATCH = 131 cycles.
        rst = 1'b0;
        clear_acc();
        run_until_lat(400);
        check("r0_cycles", acc_cyc, 131);
        check("r0_sclk", acc_sclk, 64);
        check("r0_oe_low", acc_oe, 0);
        check("r0_row_addr", row_addr, 0);
        check("r0_lat_oe_n", oe_n, 1);
        check("r0_frame_done", frame_done, 0);

        // Row 1 shifts while row 0 is displayed.
        clear_acc();
        step(1);
        check("r1_lat_low", lat, 0);
        check("r1_oe_on", oe_n, 0);
        check("r1_req", pix_req, 1);
        check("r1_pix_row", pix_row, 1);
        check("r1_pix_col", pix_col, 0);
        step(7);
        check("c3_sclk", sclk, 1);
        check("c3_pix_col", pix_col, 3);
        check("c3_rgb0", rgb0, 3);
        check("c3_rgb1", rgb1, 1);
        check("c3_req", pix_req, 0);
        step(1);
        check("c4_sclk_low", sclk, 0);
        check("c4_req", pix_req, 1);
        check("c4_pix_col", pix_col, 4);
        step(1);
        check("c4_shift", sclk, 1);

        // Acknowledge for column 5 arrives three cycles late.
        pix_valid = 1'b0;
        stall_cnt = 0;
        repeat (4) begin
            step(1);
            if (pix_req === 1'b1 && pix_col === 6'd5 && sclk === 1'b0) stall_cnt++;
        end
        pix_valid = 1'b1;
        check("c5_stall_cycles", stall_cnt, 4);
        step(1);
        check("c5_shift", sclk, 1);
        check("c5_req_low", pix_req, 0);
        check("c5_rgb0", rgb0, 5);
        run_until_lat(400);
        check("r1_cycles", acc_cyc, 259);
        check("r1_sclk", acc_sclk, 64);
        check("r1_oe_low", acc_oe, EXP_LIT);
        check("r1_row_addr", row_addr, 1);

        // Remaining rows of the frame; frame_done only at row 15.
        fd_total = 0;
        for (int r = 2; r < 16; r++) begin
            clear_acc();
            run_until_lat(400);
            check("row_cycles", acc_cyc, 259);
            check("row_addr", row_addr, 32'(r));
            check("row_frame_done", frame_done, (r == 15) ? 1 : 0);
            fd_total += acc_fd;
        end
        check("frame_done_pulses", fd_total, 1);
        clear_acc();
        step(1);
        check("frame_done_one_cycle", frame_done, 0);
        run_until_lat(400);
        check("wrap_cycles", acc_cyc, 259);
        check("wrap_row_addr", row_addr, 0);

`ifdef SCAN_DIM_EN
        bright = 8'd0;
        clear_acc();
        run_until_lat(400);
        check("dim0_oe_low", acc_oe, 0);
        bright = 8'd10;
`endif

        // en drops at column 30; the row still completes and latches.
        clear_acc();
        step(61);
        check("drop_pix_col", pix_col, 30);
        check("drop_req", pix_req, 1);
        en = 1'b0;
        run_until_lat(400);
        check("drop_cycles", acc_cyc, 259);
        check("drop_sclk", acc_sclk, 64);
        check("drop_row_addr", row_addr, 32'(1 + DIM_ROWS));

        clear_acc();
        step(1);
        check("stop_no_fetch", pix_req, 0);
        step(256);
        check("stop_oe_low", acc_oe, EXP_LIT);
        check("stop_window_end", oe_n, 1);
        step(5);
        check("stop_sclk", acc_sclk, 0);
        check("stop_lat", acc_lat, 0);
        check("idle_oe_n", oe_n, 1);
        check("idle_req", pix_req, 0);

        // Restart, then reset in the middle of a SHIFT cycle.
        en = 1'b1;
        got_sclk = 1'b0;
        for (int i = 0; i < 10 && !got_sclk; i++) begin
            step(1);
            if (sclk === 1'b1) got_sclk = 1'b1;
        end
        check("restart_shift", 32'(got_sclk), 1);
        rst = 1'b1;
        #1;
        check("arst_sclk", sclk, 0);
        check("arst_req", pix_req, 0);
        check("arst_oe_n", oe_n, 1);
        check("arst_row_addr", row_addr, 0);
        check("arst_pix_row", pix_row, 0);
        check("arst_rgb1", rgb1, 0);
        check("arst_lat", lat, 0);
        step(2);
        rst = 1'b0;
        clear_acc();
        run_until_lat(400);
        check("rerun_cycles", acc_cyc, 131);
        check("rerun_sclk", acc_sclk, 64);
        check("rerun_row_addr", row_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
